// File: rtl/data_mem_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder_pkg                                       |
// | Description : Shared constants for the data-memory responder: FSM state    |
// |               encoding, default geometry/latency, latched request record   |
// |               and the word-range helper.                                   |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package data_mem_responder_pkg;

  localparam int c_DATA_W          = 32;
  localparam int c_DEFAULT_DEPTH   = 256;
  localparam int c_DEFAULT_LATENCY = 2;

  // Responder FSM encoding; busy is derived from c_ST_WAIT only.
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  // Request fields captured at the acceptance edge.
  typedef struct packed {
    logic                we;
    logic [3:0]          mask;
    logic [c_DATA_W-1:0] addr;
    logic [c_DATA_W-1:0] wdata;
  } req_t;

  // True when the word index addr[31:2] falls inside an array of 'depth' words.
  function automatic logic word_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder_if                                        |
// | Description : Request/response bundle between the pipeline memory stage    |
// |               (master) and the data-memory responder (slave).              |
// | Signals     : req, we, mask[3:0], addr[31:0], wdata[31:0]  master -> slave |
// |               dmem_valid, rdata[31:0], err, busy           slave -> master |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic                req;
  logic                we;
  logic [3:0]          mask;
  logic [c_DATA_W-1:0] addr;
  logic [c_DATA_W-1:0] wdata;
  logic                dmem_valid;
  logic [c_DATA_W-1:0] rdata;
  logic                err;
  logic                busy;

  modport master (
    output req, we, mask, addr, wdata,
    input  dmem_valid, rdata, err, busy
  );

  modport slave (
    input  req, we, mask, addr, wdata,
    output dmem_valid, rdata, err, busy
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_dmem_array.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_array                                                   |
// | Description : DEPTH x 32-bit storage, one synchronous byte-enabled write   |
// |               port and one synchronous read port. No reset on contents so  |
// |               it can be replaced by a technology SRAM macro.               |
// | Ports       : clk            rising-edge clock                             |
// |               i_we           write enable                                  |
// |               i_be[3:0]      byte-lane enables for the write               |
// |               i_widx         write word index                              |
// |               i_wdata[31:0]  write data, lane aligned                      |
// |               i_re           read enable                                   |
// |               i_ridx         read word index                               |
// |               o_rdata[31:0]  registered read data                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [3:0]       i_be,
  input  wire logic [IDX_W-1:0] i_widx,
  input  wire logic [31:0]      i_wdata,
  input  wire logic             i_re,
  input  wire logic [IDX_W-1:0] i_ridx,
  output logic      [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_ridx];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder                                           |
// | Description : Fixed-latency data-memory responder for the pipeline memory  |
// |               stage. Accepts one load/store at a time, answers with a      |
// |               one-cycle dmem_valid pulse LATENCY edges after acceptance.   |
// | Ports       : clk   rising-edge clock                                      |
// |               rst   synchronous active-low reset                           |
// |               bus   data_mem_responder_if.slave (req/we/mask/addr/wdata in,|
// |                     dmem_valid/rdata/err/busy out)                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = c_DEFAULT_DEPTH,
  parameter int LATENCY = c_DEFAULT_LATENCY
) (
  input  wire logic            clk,
  input  wire logic            rst,
  data_mem_responder_if.slave  bus
);

  localparam int         c_IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  req_t               r_req;
  req_t               w_op;
  logic               r_load_ok;
  logic               r_err;
  logic               w_accept;
  logic               w_enter_resp;
  logic               w_in_range;
  logic               w_wr_en;
  logic               w_rd_en;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_arr_rdata;

  // Requests are only looked at outside WAIT; anything raised in WAIT is dropped.
  assign w_accept = bus.req && ((r_state == c_ST_IDLE) || (r_state == c_ST_RESP));

  // The operation being serviced: with LATENCY=1 the array access happens on
  // the acceptance edge itself, so the live bus fields must be used then.
  always_comb begin
    w_op = r_req;
    if (w_accept) begin
      w_op.we    = bus.we;
      w_op.mask  = bus.mask;
      w_op.addr  = bus.addr;
      w_op.wdata = bus.wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE, c_ST_RESP: begin
        if (w_accept) begin
          w_cnt_nxt   = c_LAT_M1;
          w_state_nxt = (LATENCY == 1) ? c_ST_RESP : c_ST_WAIT;
        end else begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = c_ST_RESP;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // The edge entering RESP performs the actual array access.
  assign w_enter_resp = (w_state_nxt == c_ST_RESP);
  assign w_in_range   = word_in_range(w_op.addr, 32'(DEPTH));
  assign w_idx        = w_op.addr[c_IDX_W+1:2];
  // Gating with rst keeps a store from landing on the edge that aborts it.
  assign w_wr_en      = rst && w_enter_resp && w_op.we && w_in_range;
  assign w_rd_en      = w_enter_resp && !w_op.we && w_in_range;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (c_IDX_W)
  ) u_dmem_array (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_be    (w_op.mask),
    .i_widx  (w_idx),
    .i_wdata (w_op.wdata),
    .i_re    (w_rd_en),
    .i_ridx  (w_idx),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= 4'd0;
      r_req     <= '0;
      r_load_ok <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_accept) begin
        r_req <= w_op;
      end
      // Both flags are only ever set on entry to RESP, so they are
      // automatically zero whenever dmem_valid is low.
      r_load_ok <= w_rd_en;
      r_err     <= w_enter_resp && !w_in_range;
    end
  end

  assign bus.dmem_valid = (r_state == c_ST_RESP);
  assign bus.busy       = (r_state == c_ST_WAIT);
  assign bus.rdata      = r_load_ok ? w_arr_rdata : 32'h0;
  assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_responder                                        |
// | Description : Self-checking bench. Three responders (LATENCY 1, 2, 3,      |
// |               DEPTH 256) share one stimulus bus with per-instance req      |
// |               enables; responses are compared against a word-array model.  |
// | Ports       : none                                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int LATS [3] = '{1, 2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_c;
  logic [2:0]  en_c;
  logic        we_c;
  logic [3:0]  mask_c;
  logic [31:0] addr_c;
  logic [31:0] wdata_c;

  data_mem_responder_if if_l1 ();
  data_mem_responder_if if_l2 ();
  data_mem_responder_if if_l3 ();

  assign if_l1.req = req_c & en_c[0];
  assign if_l2.req = req_c & en_c[1];
  assign if_l3.req = req_c & en_c[2];
  assign if_l1.we = we_c;     assign if_l2.we = we_c;     assign if_l3.we = we_c;
  assign if_l1.mask = mask_c; assign if_l2.mask = mask_c; assign if_l3.mask = mask_c;
  assign if_l1.addr = addr_c; assign if_l2.addr = addr_c; assign if_l3.addr = addr_c;
  assign if_l1.wdata = wdata_c; assign if_l2.wdata = wdata_c; assign if_l3.wdata = wdata_c;

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if_l1));
  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(if_l2));
  data_mem_responder #(.DEPTH(256), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .bus(if_l3));

  logic [2:0]  v_valid, v_busy, v_err;
  logic [31:0] v_rdata [3];
  assign v_valid = {if_l3.dmem_valid, if_l2.dmem_valid, if_l1.dmem_valid};
  assign v_busy  = {if_l3.busy, if_l2.busy, if_l1.busy};
  assign v_err   = {if_l3.err, if_l2.err, if_l1.err};
  assign v_rdata[0] = if_l1.rdata;
  assign v_rdata[1] = if_l2.rdata;
  assign v_rdata[2] = if_l3.rdata;

  int checks   = 0;
  int failures = 0;

  // Reference contents of each instance's array.
  logic [31:0] mdl [3][256];

  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t tbl [14];

  function automatic logic [34:0] obs(input int i);
    return {v_busy[i], v_valid[i], v_err[i], v_rdata[i]};
  endfunction

  // Compared value layout: {busy, dmem_valid, err, rdata}.
  task automatic chk(input string nm, input int i, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s L%0d actual{busy,valid,err,rdata}=%h required=%h", nm, LATS[i], act, exp);
    end
  endtask

  // Issue one request to the enabled instances, then watch five sampling
  // points. The response must appear exactly LATENCY-1 edges after the
  // acceptance edge; busy must be high on every sample before it.
  task automatic op(input logic [2:0] en, input logic we, input logic [3:0] mask,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input bit from_model, input logic [31:0] t_rd, input logic t_err,
                    input string nm);
    logic [31:0] e_rd [3];
    logic        e_err [3];
    logic        inr;
    int          idx;
    logic        ev, eb;
    inr = (addr[31:10] == 22'h0);
    idx = int'(addr[9:2]);
    @(negedge clk);
    en_c = en; we_c = we; mask_c = mask; addr_c = addr; wdata_c = wdata; req_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (from_model) begin
        e_rd[i]  = (!we && inr) ? mdl[i][idx] : 32'h0;
        e_err[i] = !inr;
      end else begin
        e_rd[i]  = t_rd;
        e_err[i] = t_err;
      end
    end
    @(posedge clk); #1;
    req_c = 1'b0;
    if (we && inr) begin
      for (int i = 0; i < 3; i++)
        if (en[i])
          for (int b = 0; b < 4; b++)
            if (mask[b]) mdl[i][idx][8*b +: 8] = wdata[8*b +: 8];
    end
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (en[i]) begin
          ev = (k == LATS[i] - 1);
          eb = (k < LATS[i] - 1);
          chk(nm, i, obs(i), {eb, ev, ev ? e_err[i] : 1'b0, ev ? e_rd[i] : 32'h0});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w;
    logic [31:0] old_w;
    logic [31:0] a;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAD_AAEF, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[6]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_AAEF, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1122_3344, 32'h0,         1'b0};
    tbl[8]  = '{1'b0, 4'h0, 32'h0000_0400, 32'h0,         32'h0,         1'b1};
    tbl[9]  = '{1'b1, 4'hF, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h1122_3344, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         1'b0};
    tbl[12] = '{1'b1, 4'h9, 32'h0000_03FE, 32'h5500_0066, 32'h0,         1'b0};
    tbl[13] = '{1'b0, 4'h0, 32'h0000_03FC, 32'h0,         32'h55FE_F066, 1'b0};

    rst = 1'b0; req_c = 1'b0; en_c = 3'b000; we_c = 1'b0;
    mask_c = 4'h0; addr_c = 32'h0; wdata_c = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("reset_state", i, obs(i), 35'h0);
    rst = 1'b1;

    // Directed vectors on all three latencies at once.
    for (int v = 0; v < 14; v++)
      op(3'b111, tbl[v].we, tbl[v].mask, tbl[v].addr, tbl[v].wdata,
         1'b0, tbl[v].rd, tbl[v].err, $sformatf("vec%0d", v));

    // Give words 0..15 known contents, then randomized traffic.
    for (int w = 0; w < 16; w++)
      op(3'b111, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b1, 32'h0, 1'b0, "init");
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0400;
      else a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      op(3'b111, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
         1'b1, 32'h0, 1'b0, "rand");
    end

    // LATENCY=1: req held across four loads, responses every cycle.
    @(negedge clk);
    en_c = 3'b001; we_c = 1'b0; mask_c = 4'h0; addr_c = 32'h0; req_c = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk("b2b", 0, obs(0), {1'b0, 1'b1, 1'b0, mdl[0][j]});
      if (j < 3) addr_c = 32'(4 * (j + 1));
      else req_c = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b_end", 0, obs(0), 35'h0);

    // LATENCY=3: store raised during WAIT must be dropped.
    @(negedge clk);
    exp_w = mdl[2][2];
    en_c = 3'b100; we_c = 1'b0; mask_c = 4'h0; addr_c = 32'h8; req_c = 1'b1;
    @(posedge clk); #1;
    chk("drop_k0", 2, obs(2), {1'b1, 1'b0, 1'b0, 32'h0});
    we_c = 1'b1; mask_c = 4'hF; wdata_c = 32'h1234_5678;
    @(posedge clk); #1;
    chk("drop_k1", 2, obs(2), {1'b1, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    chk("drop_resp", 2, obs(2), {1'b0, 1'b1, 1'b0, exp_w});
    req_c = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("drop_single", 2, obs(2), 35'h0);
    end
    op(3'b100, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0, "drop_noeffect");
    op(3'b100, 1'b1, 4'hF, 32'h8, 32'h1234_5678, 1'b1, 32'h0, 1'b0, "reissue");
    op(3'b100, 1'b0, 4'h0, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0, "reissue_rd");

    // Reset during WAIT aborts a pending store.
    old_w = mdl[2][5];
    @(negedge clk);
    en_c = 3'b100; we_c = 1'b1; mask_c = 4'hF; addr_c = 32'h14; wdata_c = 32'hBADC_0FFE;
    req_c = 1'b1;
    @(posedge clk); #1;
    req_c = 1'b0;
    chk("rst_wait", 2, obs(2), {1'b1, 1'b0, 1'b0, 32'h0});
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_mid", 2, obs(2), 35'h0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rst_nopulse", 2, obs(2), 35'h0);
    end
    op(3'b100, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0, old_w, 1'b0, "rst_nowrite");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the backing array (power of two, 4..4096).
REQ-002 Parameter LATENCY, default 2, number of clock edges from request acceptance to response (1..15).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 req  input  1  request strobe from the pipeline memory stage.
REQ-007 we  input  1  1 = store, 0 = load, sampled with req.
REQ-008 mask  input  4  byte enables for stores (bit i = byte lane i), ignored for loads.
REQ-009 addr  input  32  byte address; word index = addr[31:2].
REQ-010 wdata  input  32  store data, lane-aligned.
REQ-011 dmem_valid  output  1  one-cycle response pulse; the pipeline PC stall on loads releases on it.
REQ-012 rdata  output  32  load data, valid while dmem_valid=1.
REQ-013 err  output  1  out-of-range access flag, valid while dmem_valid=1.
REQ-014 busy  output  1  request in flight; req is ignored while busy=1.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; busy SHALL be 1 only in WAIT.
REQ-016 A request SHALL be accepted on a rising edge where req=1 and state is IDLE or RESP; addr, we, mask and wdata are latched at that edge.
REQ-017 On acceptance, a down-counter SHALL load LATENCY-1; next state is RESP if LATENCY=1, else WAIT.
REQ-018 In WAIT the counter SHALL decrement each edge; at count 1 the next state is RESP.
REQ-019 dmem_valid SHALL be 1 exactly in RESP, i.e. the cycle after the LATENCY-th edge following acceptance, for exactly one cycle per request.
REQ-020 From RESP, next state SHALL be IDLE if req=0, or the REQ-017 target if req=1 (back-to-back, no bubble for LATENCY=1).
REQ-021 Loads: rdata in RESP SHALL equal array[word index] as of the acceptance edge plus any store completed since then.
REQ-022 Stores: the masked bytes SHALL be written on the edge entering RESP; unmasked bytes unchanged; rdata SHALL be 0 for stores.
REQ-023 addr[1:0] SHALL be ignored (no alignment fault); byte placement is the caller's responsibility via mask.
REQ-024 Word index >= DEPTH: err=1 in RESP, load returns rdata=0, store SHALL not modify the array.
REQ-025 rdata and err SHALL be 0 whenever dmem_valid=0.
REQ-026 req while busy=1 SHALL be dropped with no side effect; the requester must hold req until acceptance.

Reset
REQ-027 While rst=0 at a rising edge: state to IDLE, counter to 0, dmem_valid, rdata, err, busy to 0.
REQ-028 Reset mid-operation SHALL abort the pending request: no response pulse, and a pending store SHALL not be written.
REQ-029 Reset SHALL not clear array contents.

Structure
REQ-030 State encoding (IDLE/WAIT/RESP) and the default DEPTH/LATENCY constants SHALL live in the shared processor package.
REQ-031 The storage array SHALL be a single sub-module, dmem_array (one synchronous write port with byte enables, one read port), so it can be swapped for a technology SRAM.

Verification
REQ-032 LATENCY=2: store addr=0x10, wdata=0xDEADBEEF, mask=0xF; then load 0x10 -> dmem_valid pulses 2 edges after each acceptance, and the load returns rdata=0xDEADBEEF, err=0.
REQ-033 Partial store mask=0x2, wdata=0x0000AA00 to 0x10 over 0xDEADBEEF; load 0x10 -> rdata=0xDEADAAEF.
REQ-034 LATENCY=1, req held high for 4 loads at 0x0, 0x4, 0x8, 0xC -> 4 consecutive dmem_valid cycles, busy never 1.
REQ-035 LATENCY=3, second req raised during WAIT -> dropped, only one dmem_valid pulse; the re-issued req after RESP is accepted.
REQ-036 DEPTH=256: load at 0x400 -> dmem_valid=1, err=1, rdata=0; store to 0x400 leaves word 0 unchanged.
REQ-037 Store accepted, rst=0 asserted in WAIT -> no dmem_valid, target word keeps its old value, all outputs 0 the cycle after reset.
